// File: rtl/rr_dec16_arbiter.sv
// rr_dec16_arbiter: round-robin owner of a shared 4:16 decoder with bounded tenure (optional ARB_LOCK_EN adds a lock input).
module rr_dec16_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ARB_LOCK_EN
  input  logic        lock,
`endif
  input  logic [15:0] req,
  output logic [3:0]  D,
  output logic        En,
  output logic [0:15] Y,
  output logic [3:0]  tenure
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [3:0] HM = 4'(HOLD_MAX);
  state_t state_q, state_d;
  logic [3:0] d_q, d_d, ptr_q, ptr_d, ten_q, ten_d, win;
  logic [0:15] y_q, y_d;
  logic en_q, en_d, own, others, at_max, locked, grant, go_idle;
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] s);
    logic [3:0] w, idx;
    logic found;
    w = s;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = s + 4'(i);
      if (!found && r[idx]) begin
        w = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction
  always_comb begin
`ifdef ARB_LOCK_EN
    locked = lock;
`else
    locked = 1'b0;
`endif
    // ptr tracks the owner while in GRANT, so one search origin serves both states
    own = req[ptr_q];
    others = |(req & ~(16'h1 << ptr_q));
    at_max = ten_q == HM;
    win = rr_pick(req, ptr_q + 4'd1);
    grant = state_q == IDLE ? |req : (!own ? others : at_max && others && !locked);
    go_idle = state_q == GRANT && !own && !others;
    state_d = grant ? GRANT : go_idle ? IDLE : state_q;
    en_d = state_d == GRANT;
    d_d = grant ? win : d_q;
    ptr_d = grant ? win : ptr_q;
    ten_d = grant ? 4'd1 : !en_d ? 4'd0 : at_max ? ten_q : ten_q + 4'd1;
    y_d = '0;
    y_d[d_d] = en_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      d_q <= '0;
      en_q <= 1'b0;
      y_q <= '0;
      ten_q <= '0;
      ptr_q <= 4'd15;
    end else begin
      state_q <= state_d;
      d_q <= d_d;
      en_q <= en_d;
      y_q <= y_d;
      ten_q <= ten_d;
      ptr_q <= ptr_d;
    end
  end
  assign D = d_q;
  assign En = en_q;
  assign Y = y_q;
  assign tenure = ten_q;
endmodule

// File: tb/tb_rr_dec16_arbiter.sv
// tb_rr_dec16_arbiter: directed vectors with a queued scoreboard checked by an independent monitor.
module tb_rr_dec16_arbiter;
  typedef struct {
    logic       en;
    logic [3:0] d;
    logic [3:0] t;
    string      name;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] req = '0;
`ifdef ARB_LOCK_EN
  logic lock = 1'b0;
`endif
  logic [3:0] d, tenure;
  logic en;
  logic [0:15] y;
  exp_t expq[$];
  int n_chk = 0;
  int n_fail = 0;
  rr_dec16_arbiter #(.HOLD_MAX(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .req(req),
    .D(d),
    .En(en),
    .Y(y),
    .tenure(tenure)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    exp_t e;
    logic [0:15] ye;
    #2;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      ye = '0;
      if (e.en) ye[e.d] = 1'b1;
      n_chk++;
      if (en !== e.en || d !== e.d || tenure !== e.t || y !== ye) begin
        n_fail++;
        $display("FAIL %s: got En=%b D=%0d tenure=%0d Y=%h, want En=%b D=%0d tenure=%0d Y=%h",
                 e.name, en, d, tenure, y, e.en, e.d, e.t, ye);
      end
    end
  end
  task automatic step(input logic r, input logic [15:0] rq, input logic e, input logic [3:0] dd,
                      input logic [3:0] t, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r;
    req = rq;
    x.en = e;
    x.d = dd;
    x.t = t;
    x.name = nm;
    expq.push_back(x);
  endtask
  initial begin
    step(1, 16'h0000, 0, 0, 0, "reset");
    for (int i = 0; i < 5; i++) step(0, 16'h0000, 0, 0, 0, "idle");
    step(0, 16'h0001, 1, 0, 1, "single_t1");
    step(0, 16'h0001, 1, 0, 2, "single_t2");
    step(0, 16'h0001, 1, 0, 3, "single_t3");
    step(0, 16'h0001, 1, 0, 4, "single_t4");
    step(0, 16'h0001, 1, 0, 4, "single_sat");
    step(0, 16'h0001, 1, 0, 4, "single_sat2");
    step(0, 16'h0000, 0, 0, 0, "single_release");
    step(1, 16'h0208, 0, 0, 0, "reset2");
    for (int k = 0; k < 2; k++) begin
      for (int t = 1; t <= 4; t++) step(0, 16'h0208, 1, 3, 4'(t), "alt_3");
      for (int t = 1; t <= 4; t++) step(0, 16'h0208, 1, 9, 4'(t), "alt_9");
    end
    step(0, 16'h0208, 1, 3, 1, "alt_back3");
    step(0, 16'h8000, 1, 15, 1, "release_switch");
    step(0, 16'h8004, 1, 15, 2, "wrap_t2");
    step(0, 16'h8004, 1, 15, 3, "wrap_t3");
    step(0, 16'h8004, 1, 15, 4, "wrap_t4");
    step(0, 16'h8004, 1, 2, 1, "wrap_to2");
    step(0, 16'h8000, 1, 15, 1, "wrap_back15");
    step(0, 16'h0200, 1, 9, 1, "own9");
    step(1, 16'h0200, 0, 0, 0, "mid_grant_reset");
    step(0, 16'h0200, 1, 9, 1, "after_reset");
    step(0, 16'h0210, 1, 9, 2, "keep9");
    step(0, 16'h0000, 0, 9, 0, "idle_hold_d");
    for (int t = 1; t <= 4; t++) step(0, 16'hFFFF, 1, 10, 4'(t), "all_10");
    step(0, 16'hFFFF, 1, 11, 1, "all_11");
`ifdef ARB_LOCK_EN
    lock = 1'b1;
    step(0, 16'h0060, 1, 5, 1, "lock_grant5");
    step(0, 16'h0060, 1, 5, 2, "lock_t2");
    step(0, 16'h0060, 1, 5, 3, "lock_t3");
    for (int i = 0; i < 21; i++) step(0, 16'h0060, 1, 5, 4, "lock_hold");
    @(negedge clk);
    lock = 1'b0;
    expq.push_back('{1'b1, 4'd6, 4'd1, "unlock_to6"});
`endif
    step(0, 16'h0000, 0, 0, 0, "final_idle");
    expq[expq.size() - 1].d = d_after_final();
    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  function automatic logic [3:0] d_after_final();
`ifdef ARB_LOCK_EN
    return 4'd6;
`else
    return 4'd11;
`endif
  endfunction
endmodule

// File: doc/rr_dec16_arbiter.md
Name: rr_dec16_arbiter

Overview:
- Round-robin arbiter sharing one 4-to-16 decoder output (one-hot select bus) among 16 requesters.
- Accepts a 16-bit request vector and picks one owner. Drives the decoder-style outputs D (binary index), En (enable) and Y (one-hot, Y[0:15]) from registers.
- Sits in front of the lab's 4:16 decoder and its downstream one-hot consumers. It replaces static testbench sequencing of D/En with fair, bounded-tenure scheduling.

Parameters:
- HOLD_MAX, 4: maximum consecutive cycles one requester keeps the grant while others wait. Legal range 1..15; the tenure counter is 4 bits wide.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous active-high reset.
- req  input  16  request vector; req[i]=1 means requester i wants the resource.
- D  output  4  binary index of the current owner (registered).
- En  output  1  grant valid / decoder enable (registered).
- Y  output  16  one-hot grant, declared [0:15]; Y[i]=1 iff En=1 and D=i.
- tenure  output  4  cycles the current owner has held the grant, 1-based; 0 when idle.

Behaviour:
- One clock, synchronous active-high reset. All state updates occur on the rising edge of clk. Outputs are registered; nothing is combinational from req.
- Reset values: D=0, En=0, Y=all zero, tenure=0, state=IDLE, internal pointer ptr=15, so the first search starts at requester 0. rst has priority over every other event, including mid-grant: the grant drops the cycle after rst is sampled high.
- Rotation search: from index s, scan s, s+1, … modulo 16 (15 wraps to 0). The first index with req=1 wins.
- State IDLE:
  - req==0: stay. En=0, Y=0, D holds its last value.
  - req!=0: next edge, enter GRANT. Winner = search from ptr+1. D=winner, En=1, Y[winner]=1, tenure=1, ptr=winner.
  - Latency is 1 cycle from req sampled to En=1.
- State GRANT, with owner o=D, evaluated each edge in this priority order:
  1. req[o]==0 (release):
     - Any other req pending: switch directly to search from o+1. No idle bubble; tenure=1.
     - Otherwise: go to IDLE. En=0, Y=0, tenure=0.
  2. req[o]==1, tenure==HOLD_MAX, and another requester pending (forced rotation): winner = search from o+1, which skips o on the first pass; tenure=1.
  3. req[o]==1, tenure==HOLD_MAX, and no other requester: keep the grant; tenure stays at HOLD_MAX (saturates).
  4. Otherwise: keep the grant; tenure increments.
- ptr is always updated to the new winner on every grant or switch.
- Invariants:
  - Y is exactly one-hot when En=1 and all zero when En=0.
  - En never deasserts between back-to-back owners.
  - A continuously asserted requester is granted within 15*HOLD_MAX cycles.
- Simultaneous events:
  - Owner releases while others request: case 1 applies; the rotation point is o+1.
  - All 16 requesting: grants cycle 0,1,…,15,0, each lasting HOLD_MAX cycles.
- HOLD_MAX=1: pure per-cycle round robin whenever there is contention.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While in GRANT with lock=1 and req[o]=1, forced rotation (case 2) is suppressed; tenure saturates at HOLD_MAX.
  - The owner releases only by dropping req[o] or by rst.
  - lock is ignored in IDLE and at the moment of grant selection.
- Undefined: no lock port; behaviour exactly as specified above.

Test Plan:
- Reset, then req=0 for 5 cycles -> D=0, En=0, Y=0, tenure=0 throughout.
- req=16'h0001 from cycle 0 -> cycle 1: En=1, D=0, Y[0]=1. Tenure counts 1,2,3,4 and then stays 4. Drop req -> next cycle En=0, Y=0.
- HOLD_MAX=4, req[3] and req[9] held high from reset -> D=3 for 4 cycles, then 9 for 4 cycles, then 3, alternating with no cycle where En=0.
- Wrap: owner 15 holds, req[2] and req[15] high; at HOLD_MAX -> D=2 (search wraps 0→2). Then drop req[2] -> D=15 the next cycle.
- Assert rst for one cycle while D=9, En=1 -> next cycle En=0, Y=0, D=0, tenure=0. With req still high -> D=0's successor search gives the lowest pending index one cycle after rst falls.
- ARB_LOCK_EN defined: req[5] and req[6] high, lock=1 while D=5 -> D stays 5 for 20+ cycles with tenure=4. Deassert lock -> D=6 on the next edge.
